// File: rtl/sprite_pkg.sv
// sprite_arbiter shared types.
// Descriptor layout, commit FSM states, screen size.
package sprite_pkg;

  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;
  localparam int ID_W     = 4;

  typedef struct packed {
    logic            en;
    logic [10:0]     x;
    logic [9:0]      y;
    logic [ID_W-1:0] id;
  } sprite_desc_t;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } commit_st_t;

endpackage

// File: rtl/sprite_hit_test.sv
// Per-slot coverage test for one sprite.
// Produces the hit flag and {row, col} offset.
module sprite_hit_test
  import sprite_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  localparam int CB    = $clog2(WIDTH),
  localparam int RB    = $clog2(HEIGHT)
) (
  input  sprite_desc_t    i_desc,
  input  logic [10:0]     i_hcount,
  input  logic [9:0]      i_vcount,
  output logic            o_hit,
  output logic [RB-1:0]   o_row,
  output logic [CB-1:0]   o_col
);

  logic [11:0] w_xend;
  logic [10:0] w_yend;
  logic        w_in_x;
  logic        w_in_y;

  // One extra bit so edge sprites never wrap.
  assign w_xend = {1'b0, i_desc.x} + 12'(WIDTH);
  assign w_yend = {1'b0, i_desc.y} + 11'(HEIGHT);

  assign w_in_x = (i_hcount >= i_desc.x) &&
                  ({1'b0, i_hcount} < w_xend);
  assign w_in_y = (i_vcount >= i_desc.y) &&
                  ({1'b0, i_vcount} < w_yend);

  assign o_hit = i_desc.en && w_in_x && w_in_y;
  assign o_col = CB'(i_hcount - i_desc.x);
  assign o_row = RB'(i_vcount - i_desc.y);

endmodule

// File: rtl/sprite_arbiter.sv
// Sprite ROM sharing: priority pick, ROM address,
// sync/blank delay and vsync-latched descriptor bank.
module sprite_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int WIDTH       = 32,
  parameter int HEIGHT      = 32,
  parameter int ID_BITS     = ID_W,
  parameter int PIPE_LAT    = 3,
  localparam int SW = $clog2(NUM_SPRITES),
  localparam int CB = $clog2(WIDTH),
  localparam int RB = $clog2(HEIGHT),
  localparam int AW = ID_BITS + RB + CB
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               blank_in,
  input  logic               desc_we,
  input  logic [SW-1:0]      desc_idx,
  input  logic               desc_en,
  input  logic [10:0]        desc_x,
  input  logic [9:0]         desc_y,
  input  logic [ID_BITS-1:0] desc_id,
  input  logic               commit_req,
  output logic               commit_pending,
  output logic               commit_done,
  output logic [AW-1:0]      rom_addr,
  output logic [SW-1:0]      sel_slot_out,
  output logic               sprite_hit_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               blank_out
);

  sprite_desc_t r_shadow [NUM_SPRITES];
  sprite_desc_t r_active [NUM_SPRITES];

  commit_st_t r_state;
  logic       r_vs_prev;
  logic       r_done;
  logic       w_vs_fall;

  logic [NUM_SPRITES-1:0] w_hit;
  logic [RB-1:0]          w_row [NUM_SPRITES];
  logic [CB-1:0]          w_col [NUM_SPRITES];

  logic          w_any;
  logic [SW-1:0] w_sel;
  logic [AW-1:0] w_addr;

  logic [AW-1:0]       r_addr;
  logic [SW-1:0]       r_sel_d [PIPE_LAT];
  logic [PIPE_LAT-1:0] r_hit_d;
  logic [PIPE_LAT-1:0] r_hs_d;
  logic [PIPE_LAT-1:0] r_vs_d;
  logic [PIPE_LAT-1:0] r_bl_d;

  assign w_vs_fall = r_vs_prev && !vsync_in;

  // Shadow bank: written any time, never shown directly.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SPRITES; i++)
        r_shadow[i] <= '0;
    end else if (desc_we) begin
      r_shadow[desc_idx] <= '{en: desc_en,
                              x:  desc_x,
                              y:  desc_y,
                              id: desc_id};
    end
  end

  // Commit FSM: shadow -> active on vsync falling edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_vs_prev <= 1'b1;
      r_done    <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++)
        r_active[i] <= '0;
    end else begin
      r_vs_prev <= vsync_in;
      r_done    <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (commit_req)
            r_state <= ST_PENDING;
        end
        ST_PENDING: begin
          if (w_vs_fall) begin
            r_state  <= ST_IDLE;
            r_done   <= 1'b1;
            r_active <= r_shadow;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign commit_pending = (r_state == ST_PENDING);
  assign commit_done    = r_done;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit_test #(
      .WIDTH (WIDTH),
      .HEIGHT(HEIGHT)
    ) u_hit (
      .i_desc  (r_active[g]),
      .i_hcount(hcount_in),
      .i_vcount(vcount_in),
      .o_hit   (w_hit[g]),
      .o_row   (w_row[g]),
      .o_col   (w_col[g])
    );
  end

  // Priority pick: lowest-index hitting slot wins.
  always_comb begin
    w_any  = 1'b0;
    w_sel  = '0;
    w_addr = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any  = 1'b1;
        w_sel  = SW'(i);
        w_addr = {r_active[i].id, w_row[i], w_col[i]};
      end
    end
  end

  // Address register and alignment delay line.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_addr  <= '0;
      r_hit_d <= '0;
      r_hs_d  <= '1;
      r_vs_d  <= '1;
      r_bl_d  <= '1;
      for (int k = 0; k < PIPE_LAT; k++)
        r_sel_d[k] <= '0;
    end else begin
      r_addr     <= w_addr;
      r_sel_d[0] <= w_sel;
      for (int k = 1; k < PIPE_LAT; k++)
        r_sel_d[k] <= r_sel_d[k-1];
      r_hit_d <= {r_hit_d[PIPE_LAT-2:0], w_any};
      r_hs_d  <= {r_hs_d[PIPE_LAT-2:0], hsync_in};
      r_vs_d  <= {r_vs_d[PIPE_LAT-2:0], vsync_in};
      r_bl_d  <= {r_bl_d[PIPE_LAT-2:0], blank_in};
    end
  end

  assign rom_addr       = r_addr;
  assign sel_slot_out   = r_sel_d[PIPE_LAT-1];
  assign sprite_hit_out = r_hit_d[PIPE_LAT-1];
  assign hsync_out      = r_hs_d[PIPE_LAT-1];
  assign vsync_out      = r_vs_d[PIPE_LAT-1];
  assign blank_out      = r_bl_d[PIPE_LAT-1];

endmodule
